// File: rtl/archon_debug_trace_tx.sv
// Debug-bus trace transmitter: captures changed CPU debug snapshots as 32-bit records,
// buffers them in a FIFO and streams them as framed bytes (SYNC + 4 record bytes).
module archon_debug_trace_tx #(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          capture_en,
    input  logic                          drop_clr,
    input  logic [3:0]                    dbg_pc,
    input  logic [15:0]                   dbg_instr,
    input  logic                          dbg_stall,
    input  logic                          dbg_flush,
    input  logic                          dbg_lock,
    input  logic                          dbg_hazard,
    input  logic [1:0]                    dbg_fsm_state,
    input  logic                          dbg_shock,
    input  logic [1:0]                    dbg_class_entropy,
    output logic [7:0]                    out_byte,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [7:0]                    drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    logic [28:0]   payload_s;
    logic [31:0]   rec_s;
    logic          cap_s;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          drop_s;
    logic          pop_s;
    logic          hs_s;

    logic [28:0]   last_q, last_d;
    logic          primed_q, primed_d;
    logic [2:0]    seq_q, seq_d;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [31:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   shreg_q, shreg_d;
    logic [7:0]    out_byte_q, out_byte_d;
    logic          out_valid_q, out_valid_d;

    assign payload_s = {dbg_pc, dbg_instr, dbg_stall, dbg_flush, dbg_lock, dbg_hazard,
                        dbg_fsm_state, dbg_shock, dbg_class_entropy};
    assign rec_s     = {seq_q, payload_s};
    assign full_s    = (level_q == LW'(FIFO_DEPTH));
    assign empty_s   = (level_q == {LW{1'b0}});
    assign hs_s      = out_valid_q && out_ready;

    // Change detection: the first enabled cycle always captures because primed is cleared while disabled.
    always_comb begin
        cap_s    = capture_en && (!primed_q || (payload_s != last_q));
        push_s   = cap_s && !full_s;
        drop_s   = cap_s && full_s;
        last_d   = last_q;
        seq_d    = seq_q;
        primed_d = primed_q;
        if (!capture_en) begin
            primed_d = 1'b0;
        end else if (cap_s) begin
            primed_d = 1'b1;
            last_d   = payload_s;
            seq_d    = seq_q + 3'd1;
        end else begin
            primed_d = primed_q;
        end
    end

    // FIFO storage, pointers, occupancy and drop accounting.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = rec_s;
            wr_ptr_d        = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1'b1);
            2'b01:   level_d = level_q - LW'(1'b1);
            default: level_d = level_q;
        endcase
        overflow_d = overflow_q | drop_s;
        if (drop_clr) begin
            drop_cnt_d = drop_s ? 8'd1 : 8'd0;
        end else if (drop_s && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Transmit FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) state_d = ST_SYNC;
                else          state_d = ST_IDLE;
            end
            ST_SYNC: begin
                if (hs_s) state_d = ST_DATA;
                else      state_d = ST_SYNC;
            end
            ST_DATA: begin
                if (hs_s && (idx_q == 2'd3)) state_d = empty_s ? ST_IDLE : ST_SYNC;
                else                         state_d = ST_DATA;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Transmit datapath: pops, shift register and registered stream outputs.
    always_comb begin
        pop_s       = 1'b0;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        out_byte_d  = out_byte_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    shreg_d     = mem_q[rd_ptr_q];
                    out_byte_d  = SYNC_BYTE;
                    out_valid_d = 1'b1;
                    idx_d       = 2'd0;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            ST_SYNC: begin
                if (hs_s) begin
                    out_byte_d = shreg_q[31:24];
                    shreg_d    = {shreg_q[23:0], 8'd0};
                    idx_d      = 2'd0;
                end else begin
                    out_byte_d = out_byte_q;
                end
            end
            ST_DATA: begin
                if (hs_s && (idx_q != 2'd3)) begin
                    out_byte_d = shreg_q[31:24];
                    shreg_d    = {shreg_q[23:0], 8'd0};
                    idx_d      = idx_q + 2'd1;
                end else if (hs_s && !empty_s) begin
                    pop_s      = 1'b1;
                    shreg_d    = mem_q[rd_ptr_q];
                    out_byte_d = SYNC_BYTE;
                    idx_d      = 2'd0;
                end else if (hs_s) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_byte_d = out_byte_q;
                end
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State register for capture, FIFO and transmit logic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q      <= 29'd0;
            primed_q    <= 1'b0;
            seq_q       <= 3'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 32'd0;
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            level_q     <= {LW{1'b0}};
            overflow_q  <= 1'b0;
            drop_cnt_q  <= 8'd0;
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            shreg_q     <= 32'd0;
            out_byte_q  <= 8'd0;
            out_valid_q <= 1'b0;
        end else begin
            last_q      <= last_d;
            primed_q    <= primed_d;
            seq_q       <= seq_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_byte   = out_byte_q;
    assign out_valid  = out_valid_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_archon_debug_trace_tx.sv
// Scoreboard bench for archon_debug_trace_tx: stimulus pushes expected frame bytes,
// a negedge monitor pops and compares on every stream handshake.
module tb_archon_debug_trace_tx;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        capture_en = 1'b0;
    logic        drop_clr = 1'b0;
    logic [3:0]  dbg_pc = 4'd0;
    logic [15:0] dbg_instr = 16'd0;
    logic        dbg_stall = 1'b0, dbg_flush = 1'b0, dbg_lock = 1'b0, dbg_hazard = 1'b0;
    logic [1:0]  dbg_fsm_state = 2'd0;
    logic        dbg_shock = 1'b0;
    logic [1:0]  dbg_class_entropy = 2'd0;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [7:0]  drop_count;

    archon_debug_trace_tx #(.FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset_n(reset_n), .capture_en(capture_en), .drop_clr(drop_clr),
        .dbg_pc(dbg_pc), .dbg_instr(dbg_instr), .dbg_stall(dbg_stall), .dbg_flush(dbg_flush),
        .dbg_lock(dbg_lock), .dbg_hazard(dbg_hazard), .dbg_fsm_state(dbg_fsm_state),
        .dbg_shock(dbg_shock), .dbg_class_entropy(dbg_class_entropy),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    logic [7:0] sb[$];
    int         checks = 0;
    int         errors = 0;
    int         hs_count = 0;
    logic [2:0] tb_seq = 3'd0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_byte = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_rec(input logic [2:0] s, input logic [3:0] pc,
                                           input logic [15:0] instr, input logic [8:0] flags);
        return {s, pc, instr, flags};
    endfunction

    task automatic push_rec(input logic [31:0] r);
        sb.push_back(8'hA5);
        sb.push_back(r[31:24]);
        sb.push_back(r[23:16]);
        sb.push_back(r[15:8]);
        sb.push_back(r[7:0]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a new snapshot; kept=1 when the record is expected on the wire, else it is dropped.
    task automatic change(input logic [15:0] instr, input logic [8:0] flags, input bit kept);
        dbg_instr = instr;
        {dbg_stall, dbg_flush, dbg_lock, dbg_hazard, dbg_fsm_state, dbg_shock, dbg_class_entropy} = flags;
        if (kept) push_rec(mk_rec(tb_seq, dbg_pc, instr, flags));
        tb_seq = tb_seq + 3'd1;
        step();
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && (sb.size() != 0 || out_valid); i++) step();
        check("drain_queue", 32'(sb.size()), 32'd0);
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_level", {28'd0, fifo_level}, 32'd0);
    endtask

    // Monitor: compare each accepted byte against the scoreboard and check stall stability.
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_valid) check("stall_hold", {24'd0, out_byte}, {24'd0, stall_byte});
            if (out_valid && out_ready) begin
                hs_count++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: actual %h required none", out_byte);
                end else begin
                    check("stream_byte", {24'd0, out_byte}, {24'd0, sb.pop_front()});
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_byte = out_byte;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] pat;
        int          base;
        pat = 16'b1011_0010_0111_0100;

        // Reset state
        #3;
        check("rst_out_byte", {24'd0, out_byte}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_level", {28'd0, fifo_level}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_drop", {24'd0, drop_count}, 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // First record: pc=3 instr=1234 -> record 32'h06246800 at seq 0
        capture_en = 1'b1;
        dbg_pc     = 4'h3;
        dbg_instr  = 16'h1234;
        sb.push_back(8'hA5); sb.push_back(8'h06); sb.push_back(8'h24);
        sb.push_back(8'h68); sb.push_back(8'h00);
        tb_seq = 3'd1;
        step();
        check("lat_level_k", {28'd0, fifo_level}, 32'd1);
        check("lat_valid_k", {31'd0, out_valid}, 32'd0);
        step();
        check("lat_valid_k1", {31'd0, out_valid}, 32'd1);
        check("lat_sync_k1", {24'd0, out_byte}, 32'h0000_00A5);
        repeat (20) step();
        check("hold_queue", 32'(sb.size()), 32'd0);
        check("hold_level", {28'd0, fifo_level}, 32'd0);
        check("hold_valid", {31'd0, out_valid}, 32'd0);

        // Fill with sink stalled: 1 in shift register, 8 in FIFO, 3 dropped
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) change(16'h0100 + 16'(i), 9'd0, i < 9);
        check("fill_level", {28'd0, fifo_level}, 32'd8);
        check("fill_drop", {24'd0, drop_count}, 32'd3);
        check("fill_overflow", {31'd0, overflow}, 32'd1);
        out_ready = 1'b1;
        wait_drain(200);
        change(16'h00FF, 9'd0, 1'b1);
        wait_drain(50);

        // Three-record burst with a toggling sink
        for (int c = 0; c < 60; c++) begin
            out_ready = pat[c % 16];
            if (c == 0)      change(16'hAAAA, 9'h1FF, 1'b1);
            else if (c == 1) change(16'h5555, 9'h155, 1'b1);
            else if (c == 2) change(16'hC3C3, 9'h0AA, 1'b1);
            else             step();
        end
        out_ready = 1'b1;
        wait_drain(100);

        // drop_clr coinciding with a drop, then saturate the drop counter
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drop_clr = (i == 9);
            change(16'h4000 + 16'(i), 9'd0, i < 9);
        end
        drop_clr = 1'b0;
        check("clr_drop", {24'd0, drop_count}, 32'd1);
        check("clr_overflow", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 300; i++) change(16'h8000 + 16'(i), 9'd0, 1'b0);
        check("sat_drop", {24'd0, drop_count}, 32'd255);
        check("sat_level", {28'd0, fifo_level}, 32'd8);
        out_ready = 1'b1;
        wait_drain(200);

        // Disable clears primed: re-enable captures even an unchanged snapshot
        capture_en = 1'b0;
        dbg_instr  = 16'h2468;
        repeat (3) step();
        check("dis_level", {28'd0, fifo_level}, 32'd0);
        check("dis_valid", {31'd0, out_valid}, 32'd0);
        capture_en = 1'b1;
        push_rec(mk_rec(tb_seq, 4'h3, 16'h2468, 9'd0));
        tb_seq = tb_seq + 3'd1;
        step();
        wait_drain(50);

        // Reset mid-frame, then fresh capture from seq 0
        base = hs_count;
        change(16'h7777, 9'd0, 1'b1);
        for (int i = 0; i < 40 && (hs_count - base) < 3; i++) step();
        check("mid_frame_reached", 32'(hs_count - base), 32'd3);
        reset_n = 1'b0;
        #1;
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_level", {28'd0, fifo_level}, 32'd0);
        check("abort_drop", {24'd0, drop_count}, 32'd0);
        check("abort_overflow", {31'd0, overflow}, 32'd0);
        sb.delete();
        tb_seq = 3'd0;
        step();
        step();
        push_rec(mk_rec(3'd0, 4'h3, 16'h7777, 9'd0));
        reset_n = 1'b1;
        step();
        wait_drain(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
